dt_tree_walker: RTL and testbench
=================================

# dt_tree_walker

Sequencer that traverses one decision tree per request, sharing a single Q32.32 `q32_comparator` instance across all internal nodes. It fetches node records from an external synchronous node memory and selects the node's feature from the feature bank. It drives the comparator with the feature and threshold, follows `go_left` to the next child, and reports the leaf class. It sits between the CAN feature-extraction stage (feature bank) and the classification result register.

## Interface
Parameters:
- NODE_AW, 8: node memory address width; root node is address 0.
- FEAT_AW, 4: feature index width.
- CLASS_W, 4: leaf class width.
- MAX_DEPTH, 16: maximum comparisons per traversal.
- CMP_TIMEOUT, 64: maximum cycles spent waiting for `cmp_done`.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a traversal; sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when a result is valid.
- error, out, 1: valid with `done`; high on depth overflow or comparator timeout.
- class_out, out, CLASS_W: leaf class; held until the next accepted `start`.
- depth_out, out, 5: comparisons performed; held alongside `class_out`.
- node_rd_en, out, 1: node memory read strobe.
- node_addr, out, NODE_AW: node memory address.
- node_is_leaf, in, 1: node field, valid the cycle after `node_rd_en`.
- node_feat_idx, in, FEAT_AW: node field, valid the cycle after `node_rd_en`.
- node_threshold, in, 64: node field (Q32.32 signed), valid the cycle after `node_rd_en`.
- node_left, in, NODE_AW: node field, valid the cycle after `node_rd_en`.
- node_right, in, NODE_AW: node field, valid the cycle after `node_rd_en`.
- node_class, in, CLASS_W: node field, valid the cycle after `node_rd_en`.
- feat_idx, out, FEAT_AW: feature bank select; `feat_data` is combinational from it.
- feat_data, in, 64: selected feature (Q32.32 signed).
- cmp_en, out, 1: comparator enable; registered.
- cmp_feature, out, 64: comparator feature input; registered, stable while `cmp_en` is high.
- cmp_threshold, out, 64: comparator threshold input; registered, stable while `cmp_en` is high.
- cmp_go_left, in, 1: comparator result (feature <= threshold).
- cmp_done, in, 1: comparator result valid.

## Operation
- States:
  - IDLE: `start` high -> FETCH. `cur_addr`=0, `depth`=0, `class_out`/`depth_out`/`error` cleared.
  - FETCH: `node_rd_en`=1, `node_addr`=`cur_addr` -> DECODE.
  - DECODE:
    - Leaf: `class_out`<=`node_class`, `error`<=0 -> DONE.
    - Non-leaf and `depth`==MAX_DEPTH: `error`<=1, `class_out`<=0 -> DONE.
    - Otherwise: `feat_idx`=`node_feat_idx`, `cmp_feature`<=`feat_data`, `cmp_threshold`<=`node_threshold`, latch `node_left`/`node_right` -> COMPARE.
  - COMPARE:
    - `cmp_en`=1 and inputs frozen.
    - On `cmp_done`=1: `cur_addr`<=`cmp_go_left` ? left : right, `depth`++ -> RELEASE.
    - Timeout counter reaches CMP_TIMEOUT: `error`<=1, `class_out`<=0 -> DONE.
  - RELEASE: `cmp_en`=0 for exactly one cycle so the comparator clears `compare_done` -> FETCH.
  - DONE: `done`=1 for one cycle, `depth_out`<=`depth` -> IDLE.
- `start` while `busy` is ignored; there is no queueing.
- Reset (async, any state) forces IDLE and clears all outputs: `busy`, `done`, `error`, `class_out`, `depth_out`, `node_rd_en`, `node_addr`, `cmp_en`, `cmp_feature`, `cmp_threshold` = 0.
- Comparisons are signed Q32.32 and performed only by the comparator; equality goes left.
- The walker does no arithmetic beyond the depth counter (5 bits, saturates at MAX_DEPTH) and the timeout counter (7 bits).
- Cycles in the tree (a child pointing back to an ancestor) terminate with `error` at MAX_DEPTH.

## Timing
- Edge 0 is the edge that accepts `start`. FETCH is cycle 1, DECODE cycle 2.
- Root leaf: `done` is high in cycle 3.
- L = edges from `cmp_en` rising to `cmp_done` sampled high; L=1 for the registered comparator.
- Each internal node costs FETCH + DECODE + COMPARE(L+1) + RELEASE = L+4 cycles.
- Depth d: `done` in cycle d·(L+4)+3. With L=1, d=2 gives cycle 13.
- `cmp_done` is ignored outside COMPARE.
- `cmp_go_left` is sampled only on the edge where `cmp_done`=1.
- `node_*` fields are sampled only in DECODE.
- `busy` falls in the cycle after `done`; a new `start` is accepted on that edge.

## Test plan
- Root node is a leaf with class 5 -> `done` in cycle 3, `class_out`=5, `error`=0, `depth_out`=0, `cmp_en` never asserted.
- Root compares f0=1.5 (0x00000001_80000000) vs 2.0; left child leaf class 1, right class 2 -> `class_out`=1, `depth_out`=1, `done` in cycle 8.
- Two-level tree:
  - Level 1: f1=-1.0 (0xFFFFFFFF_00000000) vs 1.0 -> left.
  - Level 2: f2=3.0 vs 2.0 -> right, to class 7.
  - Required: `class_out`=7, `depth_out`=2, `done` in cycle 13. Also f=2.0 vs 2.0 takes the left branch.
- Self-looping non-leaf node -> after 16 comparisons `done` with `error`=1, `class_out`=0, `depth_out`=16.
- Comparator model that never raises `cmp_done` -> `error`=1 after 64 COMPARE cycles.
- Failure cases:
  - `rst_n` pulsed low during COMPARE -> `cmp_en`/`busy` drop immediately; next `start` traverses normally from root.
  - `start` asserted while `busy` -> ignored.

Source files
------------

// File: rtl/dt_tree_walker.sv
// Decision-tree walker: fetches node records, drives a shared Q32.32 comparator
// with feature/threshold pairs and follows its go_left result down to a leaf.
module dt_tree_walker #(
   parameter int unsigned NODE_AW     = 8,
   parameter int unsigned FEAT_AW     = 4,
   parameter int unsigned CLASS_W     = 4,
   parameter int unsigned MAX_DEPTH   = 16,
   parameter int unsigned CMP_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [CLASS_W-1:0] class_out,
   output logic [4:0]         depth_out,
   output logic               node_rd_en,
   output logic [NODE_AW-1:0] node_addr,
   input  logic               node_is_leaf,
   input  logic [FEAT_AW-1:0] node_feat_idx,
   input  logic [63:0]        node_threshold,
   input  logic [NODE_AW-1:0] node_left,
   input  logic [NODE_AW-1:0] node_right,
   input  logic [CLASS_W-1:0] node_class,
   output logic [FEAT_AW-1:0] feat_idx,
   input  logic [63:0]        feat_data,
   output logic               cmp_en,
   output logic [63:0]        cmp_feature,
   output logic [63:0]        cmp_threshold,
   input  logic               cmp_go_left,
   input  logic               cmp_done
);

   localparam int unsigned DEPTH_W = 5;
   localparam int unsigned TMO_W   = 7;
   localparam int unsigned DATA_W  = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_COMPARE,
      S_RELEASE,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [NODE_AW-1:0]   cur_addr_q, cur_addr_d;
   logic [NODE_AW-1:0]   left_q, left_d;
   logic [NODE_AW-1:0]   right_q, right_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic [CLASS_W-1:0]   class_q, class_d;
   logic [DEPTH_W-1:0]   depth_out_q, depth_out_d;
   logic                 node_rd_en_q, node_rd_en_d;
   logic [NODE_AW-1:0]   node_addr_q, node_addr_d;
   logic                 cmp_en_q, cmp_en_d;
   logic [DATA_W-1:0]    cmp_feature_q, cmp_feature_d;
   logic [DATA_W-1:0]    cmp_threshold_q, cmp_threshold_d;

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cur_addr_q      <= '0;
         left_q          <= '0;
         right_q         <= '0;
         depth_q         <= '0;
         tmo_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         class_q         <= '0;
         depth_out_q     <= '0;
         node_rd_en_q    <= 1'b0;
         node_addr_q     <= '0;
         cmp_en_q        <= 1'b0;
         cmp_feature_q   <= '0;
         cmp_threshold_q <= '0;
      end else begin
         state_q         <= state_d;
         cur_addr_q      <= cur_addr_d;
         left_q          <= left_d;
         right_q         <= right_d;
         depth_q         <= depth_d;
         tmo_q           <= tmo_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
         class_q         <= class_d;
         depth_out_q     <= depth_out_d;
         node_rd_en_q    <= node_rd_en_d;
         node_addr_q     <= node_addr_d;
         cmp_en_q        <= cmp_en_d;
         cmp_feature_q   <= cmp_feature_d;
         cmp_threshold_q <= cmp_threshold_d;
      end
   end

   // Next-state logic; registered strobes are derived from the state being entered
   always_comb begin
      state_d         = state_q;
      cur_addr_d      = cur_addr_q;
      left_d          = left_q;
      right_d         = right_q;
      depth_d         = depth_q;
      tmo_d           = tmo_q;
      error_d         = error_q;
      class_d         = class_q;
      depth_out_d     = depth_out_q;
      node_addr_d     = node_addr_q;
      cmp_feature_d   = cmp_feature_q;
      cmp_threshold_d = cmp_threshold_q;
      feat_idx        = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               cur_addr_d  = '0;
               depth_d     = '0;
               class_d     = '0;
               depth_out_d = '0;
               error_d     = 1'b0;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            feat_idx = node_feat_idx;
            if (node_is_leaf) begin
               class_d = node_class;
               error_d = 1'b0;
               state_d = S_DONE;
            end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
               error_d = 1'b1;
               class_d = '0;
               state_d = S_DONE;
            end else begin
               cmp_feature_d   = feat_data;
               cmp_threshold_d = node_threshold;
               left_d          = node_left;
               right_d         = node_right;
               tmo_d           = '0;
               state_d         = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (cmp_done) begin
               cur_addr_d = cmp_go_left ? left_q : right_q;
               if (depth_q < DEPTH_W'(MAX_DEPTH)) begin
                  depth_d = depth_q + DEPTH_W'(1);
               end
               state_d = S_RELEASE;
            end else if (tmo_q == TMO_W'(CMP_TIMEOUT - 1)) begin
               error_d = 1'b1;
               class_d = '0;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         // One cycle with cmp_en low lets the comparator drop its done flag
         S_RELEASE: begin
            state_d = S_FETCH;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      node_rd_en_d = (state_d == S_FETCH);
      cmp_en_d     = (state_d == S_COMPARE);
      if (state_d == S_FETCH) begin
         node_addr_d = cur_addr_d;
      end
      if (state_d == S_DONE) begin
         depth_out_d = depth_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign class_out     = class_q;
   assign depth_out     = depth_out_q;
   assign node_rd_en    = node_rd_en_q;
   assign node_addr     = node_addr_q;
   assign cmp_en        = cmp_en_q;
   assign cmp_feature   = cmp_feature_q;
   assign cmp_threshold = cmp_threshold_q;

endmodule

// File: tb/tb_dt_tree_walker.sv
// Bench for dt_tree_walker: node memory, feature bank and registered comparator
// models, with a scoreboard of expected class/error/depth/done-cycle per traversal.
module tb_dt_tree_walker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  class_out;
   logic [4:0]  depth_out;
   logic        node_rd_en;
   logic [7:0]  node_addr;
   logic        node_is_leaf;
   logic [3:0]  node_feat_idx;
   logic [63:0] node_threshold;
   logic [7:0]  node_left;
   logic [7:0]  node_right;
   logic [3:0]  node_class;
   logic [3:0]  feat_idx;
   logic [63:0] feat_data;
   logic        cmp_en;
   logic [63:0] cmp_feature;
   logic [63:0] cmp_threshold;
   logic        cmp_go_left;
   logic        cmp_done;

   dt_tree_walker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .error(error), .class_out(class_out), .depth_out(depth_out),
      .node_rd_en(node_rd_en), .node_addr(node_addr),
      .node_is_leaf(node_is_leaf), .node_feat_idx(node_feat_idx),
      .node_threshold(node_threshold), .node_left(node_left),
      .node_right(node_right), .node_class(node_class),
      .feat_idx(feat_idx), .feat_data(feat_data),
      .cmp_en(cmp_en), .cmp_feature(cmp_feature), .cmp_threshold(cmp_threshold),
      .cmp_go_left(cmp_go_left), .cmp_done(cmp_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        mem_leaf [256];
   logic [3:0]  mem_feat [256];
   logic [63:0] mem_thr  [256];
   logic [7:0]  mem_l    [256];
   logic [7:0]  mem_r    [256];
   logic [3:0]  mem_cls  [256];
   logic [63:0] fbank    [16];
   logic        cmp_dead;
   logic        cmp_seen;

   // Synchronous node memory
   always @(posedge clk) begin
      if (node_rd_en) begin
         node_is_leaf   <= mem_leaf[node_addr];
         node_feat_idx  <= mem_feat[node_addr];
         node_threshold <= mem_thr[node_addr];
         node_left      <= mem_l[node_addr];
         node_right     <= mem_r[node_addr];
         node_class     <= mem_cls[node_addr];
      end
   end

   assign feat_data = fbank[feat_idx];

   // Registered signed comparator, equality goes left
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_done    <= 1'b0;
         cmp_go_left <= 1'b0;
      end else if (cmp_en && !cmp_dead) begin
         cmp_done    <= 1'b1;
         cmp_go_left <= ($signed(cmp_feature) <= $signed(cmp_threshold));
      end else begin
         cmp_done <= 1'b0;
      end
   end

   always @(posedge clk) if (cmp_en) cmp_seen <= 1'b1;

   typedef struct {
      string      tag;
      logic [3:0] cls;
      logic       err;
      logic [4:0] dep;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [63:0] Q_M1  = 64'hFFFFFFFF_00000000;
   localparam logic [63:0] Q_1   = 64'h00000001_00000000;
   localparam logic [63:0] Q_1_5 = 64'h00000001_80000000;
   localparam logic [63:0] Q_2   = 64'h00000002_00000000;
   localparam logic [63:0] Q_3   = 64'h00000003_00000000;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_node(input logic [7:0] a, input logic leaf, input logic [3:0] f,
                           input logic [63:0] thr, input logic [7:0] l, input logic [7:0] r,
                           input logic [3:0] cls);
      mem_leaf[a] = leaf; mem_feat[a] = f; mem_thr[a] = thr;
      mem_l[a] = l; mem_r[a] = r; mem_cls[a] = cls;
   endtask

   // Launch one traversal, optionally poking start while busy, and score the result
   task automatic run(input string tag, input logic [3:0] cls, input logic err,
                      input logic [4:0] dep, input int cyc, input logic poke);
      exp_t e;
      exp_t got;
      int   c;
      bit   seen;
      e.tag = tag; e.cls = cls; e.err = err; e.dep = dep; e.cyc = cyc;
      exp_q.push_back(e);
      cmp_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c = 1;
      seen = 1'b0;
      while (!seen && c < 300) begin
         @(posedge clk);
         c++;
         #1;
         if (poke) start = (c >= 3 && c <= 5);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      got = exp_q.pop_front();
      chk({got.tag, "_done_seen"}, 64'(seen), 64'd1);
      chk({got.tag, "_done_cycle"}, 64'(c), 64'(got.cyc));
      chk({got.tag, "_class"}, 64'(class_out), 64'(got.cls));
      chk({got.tag, "_error"}, 64'(error), 64'(got.err));
      chk({got.tag, "_depth"}, 64'(depth_out), 64'(got.dep));
      @(posedge clk);
      #1;
      chk({got.tag, "_busy_after"}, 64'(busy), 64'd0);
      chk({got.tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({got.tag, "_class_held"}, 64'(class_out), 64'(got.cls));
   endtask

   initial begin
      int c;
      start    = 1'b0;
      cmp_dead = 1'b0;
      cmp_seen = 1'b0;
      rst_n    = 1'b0;
      for (int i = 0; i < 256; i++) set_node(8'(i), 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd0);
      for (int i = 0; i < 16; i++) fbank[i] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_class", 64'(class_out), 64'd0);
      chk("rst_depth", 64'(depth_out), 64'd0);
      chk("rst_rd_en", 64'(node_rd_en), 64'd0);
      chk("rst_addr", 64'(node_addr), 64'd0);
      chk("rst_cmp_en", 64'(cmp_en), 64'd0);
      chk("rst_cmp_feat", cmp_feature, 64'd0);
      chk("rst_cmp_thr", cmp_threshold, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Root leaf
      set_node(8'd0, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd5);
      run("root_leaf", 4'd5, 1'b0, 5'd0, 3, 1'b0);
      chk("root_leaf_no_cmp", 64'(cmp_seen), 64'd0);

      // One comparison: 1.5 <= 2.0 goes left
      set_node(8'd0, 1'b0, 4'd0, Q_2, 8'd1, 8'd2, 4'd0);
      set_node(8'd1, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd1);
      set_node(8'd2, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd2);
      fbank[0] = Q_1_5;
      run("depth1", 4'd1, 1'b0, 5'd1, 8, 1'b0);

      // Two levels: -1.0 <= 1.0 left, then 3.0 > 2.0 right
      set_node(8'd0, 1'b0, 4'd1, Q_1, 8'd3, 8'd4, 4'd0);
      set_node(8'd3, 1'b0, 4'd2, Q_2, 8'd5, 8'd6, 4'd0);
      set_node(8'd4, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd9);
      set_node(8'd5, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd3);
      set_node(8'd6, 1'b1, 4'd0, 64'd0, 8'd0, 8'd0, 4'd7);
      fbank[1] = Q_M1;
      fbank[2] = Q_3;
      run("depth2_right", 4'd7, 1'b0, 5'd2, 13, 1'b0);
      fbank[2] = Q_2;
      run("depth2_equal", 4'd3, 1'b0, 5'd2, 13, 1'b0);

      // Self loop saturates at MAX_DEPTH
      set_node(8'd0, 1'b0, 4'd0, Q_2, 8'd0, 8'd0, 4'd6);
      run("self_loop", 4'd0, 1'b1, 5'd16, 83, 1'b0);

      // Comparator never answers
      cmp_dead = 1'b1;
      run("cmp_timeout", 4'd0, 1'b1, 5'd0, 67, 1'b0);
      cmp_dead = 1'b0;

      // Reset during COMPARE, then a clean traversal
      set_node(8'd0, 1'b0, 4'd0, Q_2, 8'd1, 8'd2, 4'd0);
      fbank[0] = Q_3;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c = 1;
      while (c < 3) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("pre_rst_cmp_en", 64'(cmp_en), 64'd1);
      chk("pre_rst_cmp_feat", cmp_feature, Q_3);
      chk("pre_rst_cmp_thr", cmp_threshold, Q_2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cmp_en", 64'(cmp_en), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("after_reset", 4'd2, 1'b0, 5'd1, 8, 1'b0);

      // start held while busy is ignored
      fbank[0] = Q_1;
      run("busy_start", 4'd1, 1'b0, 5'd1, 8, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("busy_start_no_retrig", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
